// File: rtl/rl_pkg.sv
// Shared types and constants for the Q-learning update engine.
// Q8.8 fixed point, four actions per row, update FSM states.
package rl_pkg;

   localparam int NUM_ACTIONS = 4;
   localparam int FRAC_W      = 8;
   localparam int Q_W         = 16;
   localparam int PROD_W      = 32;

   typedef logic signed [Q_W-1:0] q88_t;

   localparam logic signed [PROD_W-1:0] SAT_MAX = 32'sh0000_7FFF;
   localparam logic signed [PROD_W-1:0] SAT_MIN = 32'shFFFF_8000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_MAX   = 3'd2,
      S_CALC  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } upd_state_e;

endpackage

// File: rtl/fxp_mul.sv
// Signed Q8.8 times unsigned Q8.8, full product arithmetic-shifted
// right by FRAC_W (floor) and truncated to P_W bits.
module fxp_mul
   import rl_pkg::*;
#(
   parameter int A_W = 16,
   parameter int B_W = 16,
   parameter int P_W = 32
) (
   input  logic signed [A_W-1:0] a,
   input  logic        [B_W-1:0] b,
   output logic signed [P_W-1:0] p
);

   logic signed [A_W+B_W:0] full;

   // Zero-extend b so the multiply stays signed throughout
   always_comb begin
      full = a * $signed({1'b0, b});
      p    = P_W'(full >>> FRAC_W);
   end

endmodule

// File: rtl/q_updater.sv
// Q-table storage with a multi-cycle temporal-difference update engine.
// Define Q_UPDATER_SAT_EN to saturate results instead of wrapping.
module q_updater
   import rl_pkg::*;
#(
   parameter  int N_STATES = 16,
   parameter  int DATA_W   = 16,
   localparam int IDX_W    = $clog2(N_STATES),
   localparam int ROW_W    = NUM_ACTIONS * DATA_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   upd_valid,
   output logic                   upd_ready,
   input  logic [IDX_W-1:0]       cur_state,
   input  logic [NUM_ACTIONS-1:0] action,
   input  logic [DATA_W-1:0]      reward,
   input  logic [IDX_W-1:0]       next_state,
   input  logic [DATA_W-1:0]      alpha,
   input  logic [DATA_W-1:0]      gamma,
   input  logic [IDX_W-1:0]       rd_state,
   output logic [ROW_W-1:0]       rd_q_values,
   output logic                   done,
   output logic                   err
);

   upd_state_e state_q;

   logic [IDX_W-1:0]       s_q, sp_q;
   logic [NUM_ACTIONS-1:0] a_q;
   logic signed [DATA_W-1:0] r_q;
   logic [DATA_W-1:0]      alpha_q, gamma_q;
   logic [ROW_W-1:0]       row_s_q, row_n_q;
   logic signed [DATA_W-1:0] max_q;
   logic [DATA_W-1:0]      wr_q;
   logic                   done_q, err_q;

   logic [ROW_W-1:0]       tbl_q [N_STATES];
   logic [ROW_W-1:0]       rd_q;

   logic                     onehot;
   logic signed [DATA_W-1:0] q_old;
   logic signed [DATA_W-1:0] max_d;
   logic signed [PROD_W-1:0] gprod, diff, aprod, res;
   logic [DATA_W-1:0]        wr_d;
   logic [ROW_W-1:0]         new_row;

   assign upd_ready   = (state_q == S_IDLE);
   assign done        = done_q;
   assign err         = err_q;
   assign rd_q_values = rd_q;

   // Action decode, old value pick and signed max over the s' row
   always_comb begin
      onehot = (a_q != '0) && ((a_q & (a_q - 1'b1)) == '0);
      q_old  = '0;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
         if (a_q[i]) q_old = $signed(row_s_q[i*DATA_W +: DATA_W]);
      end
      max_d = $signed(row_n_q[DATA_W-1:0]);
      for (int i = 1; i < NUM_ACTIONS; i++) begin
         if ($signed(row_n_q[i*DATA_W +: DATA_W]) > max_d)
            max_d = $signed(row_n_q[i*DATA_W +: DATA_W]);
      end
   end

   fxp_mul #(.A_W(DATA_W), .B_W(DATA_W), .P_W(PROD_W)) u_mul_gamma (
      .a (max_q),
      .b (gamma_q),
      .p (gprod)
   );

   fxp_mul #(.A_W(PROD_W), .B_W(DATA_W), .P_W(PROD_W)) u_mul_alpha (
      .a (diff),
      .b (alpha_q),
      .p (aprod)
   );

   // TD error and new value, all at 32 bits, then narrowed for the table
   always_comb begin
      diff = PROD_W'(r_q) + gprod - PROD_W'(q_old);
      res  = PROD_W'(q_old) + aprod;
`ifdef Q_UPDATER_SAT_EN
      if (res > SAT_MAX)      wr_d = DATA_W'(SAT_MAX);
      else if (res < SAT_MIN) wr_d = DATA_W'(SAT_MIN);
      else                    wr_d = DATA_W'(res);
`else
      wr_d = DATA_W'(res);
`endif
   end

   // Merge the new value into the selected lane of the snapshot row
   always_comb begin
      new_row = row_s_q;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
         if (a_q[i]) new_row[i*DATA_W +: DATA_W] = wr_q;
      end
   end

   // Update FSM: capture, fetch, max, calc, write, done
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         s_q     <= '0;
         sp_q    <= '0;
         a_q     <= '0;
         r_q     <= '0;
         alpha_q <= '0;
         gamma_q <= '0;
         row_s_q <= '0;
         row_n_q <= '0;
         max_q   <= '0;
         wr_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (upd_valid) begin
                  s_q     <= cur_state;
                  sp_q    <= next_state;
                  a_q     <= action;
                  r_q     <= $signed(reward);
                  alpha_q <= alpha;
                  gamma_q <= gamma;
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: begin
               row_s_q <= tbl_q[s_q];
               row_n_q <= tbl_q[sp_q];
               state_q <= S_MAX;
            end
            S_MAX: begin
               max_q   <= max_d;
               state_q <= S_CALC;
            end
            S_CALC: begin
               wr_q    <= wr_d;
               state_q <= S_WRITE;
            end
            S_WRITE: begin
               done_q  <= 1'b1;
               err_q   <= ~onehot;
               state_q <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Table storage and registered read port (old data on same-cycle write)
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_STATES; i++) tbl_q[i] <= '0;
         rd_q <= '0;
      end else begin
         rd_q <= tbl_q[rd_state];
         if (state_q == S_WRITE && onehot) tbl_q[s_q] <= new_row;
      end
   end

endmodule

// File: tb/tb_q_updater.sv
// Directed bench for q_updater: vector table plus reset-abort and
// held-valid sequences.
module tb_q_updater;

   logic        clk;
   logic        rst;
   logic        upd_valid;
   logic        upd_ready;
   logic [3:0]  cur_state;
   logic [3:0]  action;
   logic [15:0] reward;
   logic [3:0]  next_state;
   logic [15:0] alpha;
   logic [15:0] gamma;
   logic [3:0]  rd_state;
   logic [63:0] rd_q_values;
   logic        done;
   logic        err;

   int n_pass;
   int n_total;

   q_updater dut (
      .clk         (clk),
      .rst         (rst),
      .upd_valid   (upd_valid),
      .upd_ready   (upd_ready),
      .cur_state   (cur_state),
      .action      (action),
      .reward      (reward),
      .next_state  (next_state),
      .alpha       (alpha),
      .gamma       (gamma),
      .rd_state    (rd_state),
      .rd_q_values (rd_q_values),
      .done        (done),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  s;
      logic [3:0]  a;
      logic [15:0] r;
      logic [3:0]  sp;
      logic [15:0] al;
      logic [15:0] ga;
      logic [3:0]  rd;
      logic [63:0] exp_row;
      logic        exp_err;
   } vec_t;

`ifdef Q_UPDATER_SAT_EN
   localparam logic [63:0] EXP_BIG = 64'h0000_0000_0000_7FFF;
`else
   localparam logic [63:0] EXP_BIG = 64'h0000_0000_0000_FE00;
`endif

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic read_row(input logic [3:0] row, output logic [63:0] val);
      @(negedge clk);
      rd_state = row;
      @(posedge clk);
      #1;
      val = rd_q_values;
   endtask

   // Launch one update; returns cycle at which done was seen (99 = never)
   task automatic do_update(input vec_t v, output int dcyc, output logic e);
      int cyc;
      bit seen;
      @(negedge clk);
      cur_state  = v.s;
      action     = v.a;
      reward     = v.r;
      next_state = v.sp;
      alpha      = v.al;
      gamma      = v.ga;
      upd_valid  = 1'b1;
      @(posedge clk);
      #1;
      upd_valid  = 1'b0;
      cur_state  = 4'hF;
      next_state = 4'hE;
      action     = 4'b0100;
      reward     = 16'h1234;
      alpha      = 16'hFFFF;
      gamma      = 16'hFFFF;
      cyc  = 1;
      seen = 1'b0;
      e    = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin
            seen = 1'b1;
            e    = err;
         end
      end
      dcyc = seen ? cyc : 99;
   endtask

   vec_t vecs[8];

   initial begin
      logic [63:0] val;
      int          dcyc;
      logic        e;
      int          d_first, d_second, d_count;
      logic        rdy6;
      vec_t        v;

      n_pass    = 0;
      n_total   = 0;
      rst       = 1'b1;
      upd_valid = 1'b0;
      cur_state = '0;
      action    = '0;
      reward    = '0;
      next_state = '0;
      alpha     = '0;
      gamma     = '0;
      rd_state  = '0;

      vecs[0] = '{4'd0, 4'b0001, 16'h0100, 4'd1, 16'h0080, 16'h00E6,
                  4'd0, 64'h0000_0000_0000_0080, 1'b0};
      vecs[1] = '{4'd1, 4'b0010, 16'h0000, 4'd0, 16'h0080, 16'h00E6,
                  4'd1, 64'h0000_0000_0039_0000, 1'b0};
      vecs[2] = '{4'd2, 4'b0001, 16'h7F00, 4'd2, 16'h0100, 16'h0000,
                  4'd2, 64'h0000_0000_0000_7F00, 1'b0};
      vecs[3] = '{4'd2, 4'b0001, 16'h7F00, 4'd2, 16'h0100, 16'h0100,
                  4'd2, EXP_BIG, 1'b0};
      vecs[4] = '{4'd0, 4'b0011, 16'h0100, 4'd1, 16'h0100, 16'h0100,
                  4'd0, 64'h0000_0000_0000_0080, 1'b1};
      vecs[5] = '{4'd1, 4'b0000, 16'h0100, 4'd0, 16'h0100, 16'h0100,
                  4'd1, 64'h0000_0000_0039_0000, 1'b1};
      vecs[6] = '{4'd3, 4'b1000, 16'hFF00, 4'd3, 16'h0100, 16'h0000,
                  4'd3, 64'hFF00_0000_0000_0000, 1'b0};
      vecs[7] = '{4'd4, 4'b0100, 16'hFFFF, 4'd4, 16'h0080, 16'h0000,
                  4'd4, 64'h0000_FFFF_0000_0000, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_rd",    rd_q_values, 64'h0);
      check("reset_done",  {63'h0, done}, 64'h0);
      check("reset_err",   {63'h0, err}, 64'h0);
      check("reset_ready", {63'h0, upd_ready}, 64'h1);

      for (int i = 0; i < 8; i++) begin
         do_update(vecs[i], dcyc, e);
         check($sformatf("v%0d_done_cyc", i), 64'(dcyc), 64'd5);
         check($sformatf("v%0d_err", i), {63'h0, e}, {63'h0, vecs[i].exp_err});
         read_row(vecs[i].rd, val);
         check($sformatf("v%0d_row", i), val, vecs[i].exp_row);
      end

      // Reset during CALC aborts the update
      v = '{4'd5, 4'b0001, 16'h0100, 4'd5, 16'h0100, 16'h0000,
            4'd5, 64'h0, 1'b0};
      @(negedge clk);
      cur_state = v.s; action = v.a; reward = v.r;
      next_state = v.sp; alpha = v.al; gamma = v.ga;
      upd_valid = 1'b1;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_ready", {63'h0, upd_ready}, 64'h1);
      d_count = 0;
      for (int k = 0; k < 8; k++) begin
         if (done) d_count++;
         @(posedge clk);
         #1;
      end
      check("abort_no_done", 64'(d_count), 64'd0);
      for (int r = 0; r < 16; r++) begin
         read_row(4'(r), val);
         check($sformatf("abort_row%0d", r), val, 64'h0);
      end

      // Valid held high through a busy update
      @(negedge clk);
      cur_state = 4'd0; action = 4'b0001; reward = 16'h0100;
      next_state = 4'd1; alpha = 16'h0080; gamma = 16'h0000;
      upd_valid = 1'b1;
      @(posedge clk);
      #1;
      d_first  = 0;
      d_second = 0;
      d_count  = 0;
      rdy6     = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (c == 7) upd_valid = 1'b0;
         if (c == 6) rdy6 = upd_ready;
         if (done) begin
            d_count++;
            if (d_first == 0) d_first = c;
            else if (d_second == 0) d_second = c;
         end
      end
      check("held_done_count",  64'(d_count), 64'd2);
      check("held_first_done",  64'(d_first), 64'd5);
      check("held_second_done", 64'(d_second), 64'd11);
      check("held_ready_idle",  {63'h0, rdy6}, 64'h1);
      read_row(4'd0, val);
      check("held_row0", val, 64'h0000_0000_0000_00C0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded");
      $fatal(1);
   end

endmodule
